// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch front end: sequential fetch, req/ack to imem, PC+word FIFO toward IF/ID
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        ce_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t        state, state_next;
  logic          ce_q;
  logic [31:0]   fetch_pc;
  logic [31:0]   disc_addr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, fifo_nonempty;

  assign ce_o          = ce_q;
  assign mem_req_o     = (state == FETCH) || (state == DISCARD);
  assign fifo_nonempty = (count != '0);
  assign inst_valid_o  = fifo_nonempty && !flush_i;
  assign inst_o        = fifo_nonempty ? data_mem[rd_ptr] : 32'h0;
  assign inst_pc_o     = fifo_nonempty ? pc_mem[rd_ptr]   : 32'h0;
  assign pop           = inst_valid_o && !stall_i;
  assign push          = (state == FETCH) && mem_ack_i && !flush_i;

  // A DISCARD request keeps its original address while fetch_pc already holds the redirect target.
  always_comb begin
    mem_addr_o = 32'h0;
    case (state)
      FETCH:   mem_addr_o = fetch_pc;
      DISCARD: mem_addr_o = disc_addr;
      default: mem_addr_o = 32'h0;
    endcase
  end

  always_comb begin
    count_next = count;
    if (flush_i) begin
      count_next = '0;
    end else begin
      count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ce_q && (count < FULL)) state_next = FETCH;
      end
      FETCH: begin
        if (mem_ack_i) begin
          state_next = (count_next < FULL) ? FETCH : IDLE;
        end else if (flush_i) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack_i) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ce_q      <= 1'b0;
      fetch_pc  <= RESET_PC;
      disc_addr <= 32'h0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      ce_q  <= 1'b1;
      state <= state_next;
      count <= count_next;
      if (flush_i) begin
        fetch_pc <= flush_pc_i & ~32'h3;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
      if ((state == FETCH) && !mem_ack_i && flush_i) disc_addr <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= mem_rdata_i;
    end
  end

endmodule
